// File: rtl/delta_h_ctrl_pkg.sv
// Shared ANN layer package: FSM state encoding and fixed-point multiplier defaults.
package delta_h_ctrl_pkg;

  localparam int unsigned ANN_WIDTH = 32;
  localparam int unsigned ANN_FRAC  = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_SCALE,
    S_OUT,
    S_DONE
  } state_t;

endpackage

// File: rtl/delta_h_ctrl_fxp_mul.sv
// Signed fixed-point multiply: full product, arithmetic shift by FRAC, keep low WIDTH bits.
module fxp_mul
  import delta_h_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = ANN_WIDTH,
  parameter int unsigned FRAC  = ANN_FRAC
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  logic signed [2*WIDTH-1:0] ae;
  logic signed [2*WIDTH-1:0] be;
  logic signed [2*WIDTH-1:0] prod;

  assign ae   = {{WIDTH{a[WIDTH-1]}}, a};
  assign be   = {{WIDTH{b[WIDTH-1]}}, b};
  assign prod = ae * be;
  // Floor rounding and wrap-around come from the shift plus plain truncation.
  assign y    = WIDTH'(prod >>> FRAC);

endmodule

// File: rtl/delta_h_ctrl.sv
// Hidden-layer delta controller: per neuron j, delta = (sum_k prevd[k]*w[j][k]) * a*(1-a).
module delta_h_ctrl
  import delta_h_ctrl_pkg::*;
#(
  parameter int unsigned NUM   = 2,
  parameter int unsigned NEUR  = 2,
  parameter int unsigned WIDTH = ANN_WIDTH,
  parameter int unsigned FRAC  = ANN_FRAC,
  localparam int unsigned KW   = (NUM  > 1) ? $clog2(NUM)  : 1,
  localparam int unsigned JW   = (NEUR > 1) ? $clog2(NEUR) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_rd,
  output logic [JW-1:0]    o_j,
  output logic [KW-1:0]    o_k,
  input  logic [WIDTH-1:0] i_prevd,
  input  logic [WIDTH-1:0] i_w,
  input  logic [WIDTH-1:0] i_a,
  output logic [WIDTH-1:0] o_delta,
  output logic [JW-1:0]    o_delta_idx,
  output logic             o_delta_valid,
  input  logic             i_delta_ready
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1) << FRAC;

  state_t state, state_nxt;

  logic [JW-1:0]    j;
  logic [KW-1:0]    k;
  logic [KW-1:0]    rk;
  logic             rvalid;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] mac_p;
  logic [WIDTH-1:0] deriv;
  logic [WIDTH-1:0] scale_p;
  logic             k_last;
  logic             j_last;

  assign k_last = (k == KW'(NUM - 1));
  assign j_last = (j == JW'(NEUR - 1));
  assign o_j    = j;
  assign o_k    = k;

  fxp_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mac (
    .a (i_prevd),
    .b (i_w),
    .y (mac_p)
  );

  fxp_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_deriv (
    .a (a_q),
    .b (ONE - a_q),
    .y (deriv)
  );

  fxp_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_scale (
    .a (acc),
    .b (deriv),
    .y (scale_p)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    o_rd      = 1'b0;
    o_busy    = 1'b1;
    o_done    = 1'b0;
    case (state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_start) state_nxt = S_RUN;
      end
      S_RUN: begin
        o_rd = 1'b1;
        if (k_last) state_nxt = S_DRAIN;
      end
      S_DRAIN: state_nxt = S_SCALE;
      S_SCALE: state_nxt = S_OUT;
      S_OUT: begin
        if (i_delta_ready) state_nxt = j_last ? S_DONE : S_RUN;
      end
      S_DONE: begin
        o_done    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Read data returns one cycle after the strobe; rvalid/rk follow each read.
  always_ff @(posedge clk) begin
    if (!rst) begin
      j             <= '0;
      k             <= '0;
      rk            <= '0;
      rvalid        <= 1'b0;
      acc           <= '0;
      a_q           <= '0;
      o_delta       <= '0;
      o_delta_idx   <= '0;
      o_delta_valid <= 1'b0;
    end else begin
      rvalid <= (state == S_RUN);
      rk     <= k;
      if (rvalid) begin
        acc <= acc + mac_p;
        if (rk == '0) a_q <= i_a;
      end
      case (state)
        S_IDLE: begin
          if (i_start) begin
            j   <= '0;
            k   <= '0;
            acc <= '0;
          end
        end
        S_RUN: begin
          if (!k_last) k <= k + 1'b1;
        end
        S_SCALE: begin
          o_delta       <= scale_p;
          o_delta_idx   <= j;
          o_delta_valid <= 1'b1;
        end
        S_OUT: begin
          if (i_delta_ready) begin
            o_delta_valid <= 1'b0;
            if (!j_last) begin
              j   <= j + 1'b1;
              k   <= '0;
              acc <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_delta_h_ctrl.sv
// Scoreboard bench for delta_h_ctrl with a memory responder answering each read strobe.
module tb_delta_h_ctrl;

  localparam int unsigned NUM   = 2;
  localparam int unsigned NEUR  = 2;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned FRAC  = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_start = 1'b0;
  logic        o_busy, o_done, o_rd;
  logic [0:0]  o_j, o_k;
  logic [31:0] i_prevd = '0;
  logic [31:0] i_w = '0;
  logic [31:0] i_a = '0;
  logic [31:0] o_delta;
  logic [0:0]  o_delta_idx;
  logic        o_delta_valid;
  logic        i_delta_ready = 1'b1;

  delta_h_ctrl #(.NUM(NUM), .NEUR(NEUR), .WIDTH(WIDTH), .FRAC(FRAC)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_start       (i_start),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_rd          (o_rd),
    .o_j           (o_j),
    .o_k           (o_k),
    .i_prevd       (i_prevd),
    .i_w           (i_w),
    .i_a           (i_a),
    .o_delta       (o_delta),
    .o_delta_idx   (o_delta_idx),
    .o_delta_valid (o_delta_valid),
    .i_delta_ready (i_delta_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] delta;
    logic        idx;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_prevd[NUM];
  logic [31:0] m_w[NEUR][NUM];
  logic [31:0] m_a[NEUR];
  logic [31:0] m_exp[NEUR];

  int cyc = 0, rd_start = 0, hs_cyc = 0, start_cyc = 0;
  int hs_count = 0, done_count = 0, exp_len = 0;
  logic prev_rd = 1'b0, prev_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},  32'(o_busy), 32'd0);
    chk({tag, "_done"},  32'(o_done), 32'd0);
    chk({tag, "_rd"},    32'(o_rd), 32'd0);
    chk({tag, "_j"},     32'(o_j), 32'd0);
    chk({tag, "_k"},     32'(o_k), 32'd0);
    chk({tag, "_delta"}, o_delta, 32'd0);
    chk({tag, "_idx"},   32'(o_delta_idx), 32'd0);
    chk({tag, "_valid"}, 32'(o_delta_valid), 32'd0);
  endtask

  // Hand-computed Q16.16 vectors; set 0 neuron 1 exercises floor rounding of -0.5 lsb.
  task automatic load_set(input int s);
    if (s == 0) begin
      m_prevd = '{32'h0001_0000, 32'h0000_8000};
      m_w[0]  = '{32'h0000_8000, 32'h0002_0000};
      m_w[1]  = '{32'h0001_0000, 32'hFFFF_FFFF};
      m_a     = '{32'h0000_8000, 32'h0000_4000};
      m_exp   = '{32'h0000_6000, 32'h0000_2FFF};
    end else begin
      m_prevd = '{32'hFFFF_0000, 32'h0000_0000};
      m_w[0]  = '{32'h0002_0000, 32'h0001_2345};
      m_w[1]  = '{32'h0000_8000, 32'h0001_0000};
      m_a     = '{32'h0001_8000, 32'h0000_8000};
      m_exp   = '{32'h0001_8000, 32'hFFFF_E000};
    end
  endtask

  initial begin : responder
    logic       rd;
    logic [0:0] jj, kk;
    forever begin
      @(negedge clk);
      rd = o_rd;
      jj = o_j;
      kk = o_k;
      @(posedge clk);
      #1;
      if (rd) begin
        i_prevd = m_prevd[kk];
        i_w     = m_w[jj][kk];
        i_a     = (kk == 1'b0) ? m_a[jj] : $urandom;
      end else begin
        i_prevd = $urandom;
        i_w     = $urandom;
        i_a     = $urandom;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        if (o_rd && !prev_rd) rd_start = cyc;
        if (o_delta_valid && !prev_valid)
          chk("latency", 32'(cyc - rd_start), 32'(NUM + 2));
        if (o_delta_valid && i_delta_ready) begin
          hs_count++;
          hs_cyc = cyc;
          if (sb.size() == 0) begin
            chk("unexpected_output", 32'(sb.size()), 32'd1);
          end else begin
            e = sb.pop_front();
            chk("delta", o_delta, e.delta);
            chk("delta_idx", 32'(o_delta_idx), 32'(e.idx));
          end
        end
        if (o_done) begin
          done_count++;
          chk("done_after_hs", 32'(cyc - hs_cyc), 32'd1);
          chk("run_len", 32'(cyc - start_cyc), 32'(exp_len));
        end
        if (i_start && !o_busy) start_cyc = cyc;
      end
      prev_rd    = o_rd;
      prev_valid = o_delta_valid;
    end
  end

  task automatic do_run(input int s, input bit bp, input bit noise);
    exp_t e;
    int   hs0, done0, bp_cnt;
    bit   done_seen, post_hs;
    load_set(s);
    for (int unsigned n = 0; n < NEUR; n++) begin
      e.delta = m_exp[n];
      e.idx   = 1'(n);
      sb.push_back(e);
    end
    exp_len       = bp ? int'(NEUR * (NUM + 3) + 1 + 5) : int'(NEUR * (NUM + 3) + 1);
    hs0           = hs_count;
    done0         = done_count;
    bp_cnt        = 0;
    done_seen     = 1'b0;
    post_hs       = 1'b0;
    i_delta_ready = !bp;
    i_start       = 1'b1;
    tick();
    i_start = 1'b0;
    for (int c = 0; c < 200 && !done_seen; c++) begin
      i_start = noise && (o_rd || o_delta_valid);
      if (post_hs) begin
        chk("bp_resume_rd", 32'(o_rd), 32'd1);
        chk("bp_resume_j", 32'(o_j), 32'd1);
        post_hs = 1'b0;
      end
      if (bp && bp_cnt < 6 && o_delta_valid && o_delta_idx == 1'b0) begin
        chk("bp_rd", 32'(o_rd), 32'd0);
        chk("bp_delta", o_delta, m_exp[0]);
        chk("bp_idx", 32'(o_delta_idx), 32'd0);
        bp_cnt++;
        i_delta_ready = (bp_cnt >= 6);
        post_hs       = (bp_cnt == 6);
      end
      done_seen = o_done;
      tick();
    end
    i_start       = 1'b0;
    i_delta_ready = 1'b1;
    chk("run_finished", 32'(done_seen), 32'd1);
    chk("hs_per_run", 32'(hs_count - hs0), 32'(NEUR));
    chk("done_per_run", 32'(done_count - done0), 32'd1);
    chk("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    bit found;
    rst = 1'b0;
    repeat (3) tick();
    chk_zero("reset");
    rst = 1'b1;
    tick();

    do_run(0, 1'b0, 1'b0);
    do_run(1, 1'b1, 1'b1);

    load_set(0);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (o_rd && o_k == 1'b1) found = 1'b1;
      else tick();
    end
    chk("reach_k1", 32'(found), 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk_zero("midrun_reset");

    do_run(0, 1'b0, 1'b0);
    do_run(0, 1'b0, 1'b0);

    repeat (3) tick();
    chk("sb_final", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
